// File: rtl/seven_seg_pkg.sv
// Shared constants for the 7-segment scanner: active-low g..a hex font, blank pattern, index sizing.
package seven_seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Entry n is the glyph for hex digit n; bit 6 = g, bit 0 = a, 0 = segment lit.
    localparam logic [15:0][6:0] HEX_FONT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble to active-low segment lookup; zero latency, no flow control.
module hex_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_FONT[nibble];

endmodule

// File: rtl/seven_seg_scanner.sv
// Self-timed multiplexed hex display driver with double-buffered value, dead-time and decimal points.
// Outputs registered one cycle behind the scan state; SEVEN_SEG_LZB_EN enables leading-zero blanking.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_PERIOD = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    enable,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int CNT_W = idx_width(DIGIT_PERIOD);
    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        div_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic [4*NUM_DIGITS-1:0] pending;
    logic [NUM_DIGITS-1:0]   pending_dp;
    logic                    pend_vld;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [NUM_DIGITS-1:0]   shadow_dp;

    logic                    tick;
    logic                    wrap;
    logic                    blank;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_lzb;
    logic [NUM_DIGITS-1:0]   lzb_mask;
    logic [6:0]              font_seg;

    assign tick  = enable && (div_cnt == CNT_LAST);
    assign wrap  = tick && (digit_idx == IDX_LAST);
    assign blank = !enable || (div_cnt < CNT_BLANK);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            digit_idx <= '0;
        end else if (enable) begin
            if (tick) begin
                div_cnt   <= '0;
                digit_idx <= wrap ? '0 : digit_idx + IDX_W'(1);
            end else begin
                div_cnt <= div_cnt + CNT_W'(1);
            end
        end
    end

    // A load landing on the wrap tick bypasses pending so it shows from digit 0 of the new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            pending_dp <= '0;
            pend_vld   <= 1'b0;
            shadow     <= '0;
            shadow_dp  <= '0;
        end else if (load) begin
            if (wrap) begin
                shadow    <= value;
                shadow_dp <= dp_in;
                pend_vld  <= 1'b0;
            end else begin
                pending    <= value;
                pending_dp <= dp_in;
                pend_vld   <= 1'b1;
            end
        end else if (wrap && pend_vld) begin
            shadow    <= pending;
            shadow_dp <= pending_dp;
            pend_vld  <= 1'b0;
        end
    end

`ifdef SEVEN_SEG_LZB_EN
    always_comb begin
        logic zero_run;
        lzb_mask = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run    = zero_run && (shadow[4*i +: 4] == 4'h0);
            lzb_mask[i] = zero_run;
        end
    end
`else
    assign lzb_mask = '0;
`endif

    always_comb begin
        cur_nib = '0;
        cur_dp  = 1'b0;
        cur_lzb = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                cur_nib = shadow[4*i +: 4];
                cur_dp  = shadow_dp[i];
                cur_lzb = lzb_mask[i];
            end
        end
    end

    hex_seg_decode u_decode (
        .nibble (cur_nib),
        .seg    (font_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (blank) begin
                seg <= SEG_OFF;
                dp  <= 1'b1;
                an  <= '1;
            end else begin
                seg <= cur_lzb ? SEG_OFF : font_seg;
                dp  <= ~cur_dp;
                an  <= ~(NUM_DIGITS'(1) << digit_idx);
            end
        end
    end

endmodule
